// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues reads to a one-cycle synchronous instruction memory,
// buffers {instr, pc} pairs in a small queue and hands them to decode over valid/ready.
// An all-zero instruction word halts fetch; a redirect flushes everything and restarts fetch.
// Optional build macro FETCH_STATS_EN adds stat_fetched / stat_stall counters.
module fetch_unit #(
    parameter int unsigned         PC_WIDTH    = 12,
    parameter int unsigned         INSTR_WIDTH = 32,
    parameter int unsigned         FIFO_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [INSTR_WIDTH-1:0] dec_instr,
    output logic [PC_WIDTH-1:0]    dec_pc,
    output logic                   halted
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]            stat_fetched,
    output logic [31:0]            stat_stall
`endif
);
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW:0] DepthVal = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]    inflight_pc_q, inflight_pc_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic [INSTR_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]    pc_mem_q [FIFO_DEPTH];

    logic            issue, resp_zero, push, pop;
    logic [CntW:0]   occupancy;

    // Credit uses registered count plus the outstanding request; same-cycle pops are ignored.
    assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign issue     = rst_n && (state_q == StRun) && !redirect_valid && (occupancy < DepthVal);
    assign resp_zero = inflight_q && (imem_rdata == '0);
    assign push      = inflight_q && !resp_zero && !redirect_valid;
    assign pop       = (count_q != '0) && dec_ready && !redirect_valid;

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign dec_valid = (count_q != '0);
    assign dec_instr = instr_mem_q[rd_ptr_q];
    assign dec_pc    = pc_mem_q[rd_ptr_q];
    assign halted    = (state_q == StHalt);

    // Next-state: fetch/queue bookkeeping, then halt, then redirect overriding everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? pc_q : inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (issue) pc_d = pc_q + PC_WIDTH'(4);
        if (push)  wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Zero word: cancel this cycle's request and park the PC just past the zero word.
        if (resp_zero && !redirect_valid) begin
            state_d    = StHalt;
            inflight_d = 1'b0;
            pc_d       = inflight_pc_q + PC_WIDTH'(4);
        end

        if (redirect_valid) begin
            state_d    = StRun;
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage; cleared on reset so dec_instr/dec_pc read zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_stall_q;

    assign stat_fetched = stat_fetched_q;
    assign stat_stall   = stat_stall_q;

    // Push counter and RUN-state credit-stall counter, both free-running mod 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_fetched_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (push) stat_fetched_q <= stat_fetched_q + 32'd1;
            if ((state_q == StRun) && !issue && !redirect_valid) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. A second instance starts at RESET_PC 0xFF8
// to exercise PC wrap. Build with FETCH_STATS_EN to also check the statistics counters.
module tb_fetch_unit;
    localparam int unsigned PW = 12;
    localparam int unsigned IW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, imem_req, redirect_valid, dec_valid, dec_ready, halted;
    logic [PW-1:0] imem_addr, redirect_pc, dec_pc;
    logic [IW-1:0] imem_rdata, dec_instr;
`ifdef FETCH_STATS_EN
    logic [31:0]   stat_fetched, stat_stall;
`endif

    logic          w_rst_n, w_imem_req, w_dec_valid, w_halted;
    logic [PW-1:0] w_imem_addr, w_dec_pc;
    logic [IW-1:0] w_imem_rdata, w_dec_instr;

    logic [IW-1:0]    mem [1024];
    logic [PW+IW-1:0] sb [$];  // {pc, instr}
    int n_cmp = 0;
    int n_bad = 0;

    fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .FIFO_DEPTH(4), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .halted(halted)
`ifdef FETCH_STATS_EN
        , .stat_fetched(stat_fetched), .stat_stall(stat_stall)
`endif
    );

    fetch_unit #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .FIFO_DEPTH(4), .RESET_PC(12'hFF8)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rdata(w_imem_rdata), .redirect_valid(1'b0), .redirect_pc(12'h000),
        .dec_valid(w_dec_valid), .dec_ready(1'b1), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
        .halted(w_halted)
`ifdef FETCH_STATS_EN
        , .stat_fetched(), .stat_stall()
`endif
    );

    // Synchronous memory; non-requested cycles return junk so spurious pushes are visible.
    always @(posedge clk) begin
        imem_rdata   <= imem_req ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;
        w_imem_rdata <= w_imem_req ? mem[w_imem_addr[11:2]] : 32'hDEAD_BEEF;
    end

    task automatic init_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 | 32'(i);
    endtask

    // Leaves the bench at a negedge with two reset edges applied and rst_n still low.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        n_cmp++; if (dec_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", dec_instr); end
        n_cmp++; if (dec_pc !== 12'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", dec_pc); end
        // Fill the queue, then reset mid-operation.
        init_mem();
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL prefill_valid: got %b want 1", dec_valid); end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL midreset_req: got %b want 0", imem_req); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid: got %b want 0", dec_valid); end
        n_cmp++; if ({dec_pc, dec_instr} !== 44'h0) begin
            n_bad++; $display("FAIL midreset_head: got %h want 0", {dec_pc, dec_instr});
        end
    endtask

    task automatic test_basic();
        init_mem();
        mem[0] = 32'h0050_0093; mem[1] = 32'h00A0_0113; mem[2] = 32'h0020_81B3;
        do_reset();
        sb.push_back({12'h000, 32'h0050_0093});
        sb.push_back({12'h004, 32'h00A0_0113});
        sb.push_back({12'h008, 32'h0020_81B3});
        for (int i = 3; i < 6; i++) sb.push_back({PW'(i * 4), 32'hC000_0000 | 32'(i)});
        dec_ready = 1'b1; rst_n = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (cyc < 2) begin
                n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid c%0d: got %b want 0", cyc, dec_valid); end
            end else begin
                n_cmp++;
                if (dec_valid !== 1'b1) begin
                    n_bad++; $display("FAIL basic_valid c%0d: got %b want 1", cyc, dec_valid);
                end else if ({dec_pc, dec_instr} !== sb[0]) begin
                    n_bad++; $display("FAIL basic_entry c%0d: got %h want %h", cyc, {dec_pc, dec_instr}, sb[0]);
                end
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] exp_pc;
        int nreq;
        init_mem();
        do_reset();
        exp_pc = 12'h000; nreq = 0; rst_n = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 8) dec_ready = 1'b1;
            #1;
            if (imem_req) begin
                n_cmp++;
                if (imem_addr !== exp_pc) begin n_bad++; $display("FAIL bp_addr c%0d: got %h want %h", cyc, imem_addr, exp_pc); end
                sb.push_back({exp_pc, mem[exp_pc[11:2]]});
                exp_pc = exp_pc + 12'd4; nreq++;
            end
            if (cyc == 7) begin
                n_cmp++; if (nreq != 4) begin n_bad++; $display("FAIL bp_reqs: got %0d want 4", nreq); end
                n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
            end
            if (dec_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL bp_unexpected c%0d: got %h want none", cyc, {dec_pc, dec_instr});
                end else begin
                    if ({dec_pc, dec_instr} !== sb[0]) begin
                        n_bad++; $display("FAIL bp_entry c%0d: got %h want %h", cyc, {dec_pc, dec_instr}, sb[0]);
                    end
                    if (dec_ready) void'(sb.pop_front());
                end
            end
        end
        n_cmp++; if (nreq < 8) begin n_bad++; $display("FAIL bp_resume: got %0d reqs want >= 8", nreq); end
    endtask

    task automatic test_halt();
        logic seen;
        init_mem();
        mem[3] = 32'h0;
        do_reset();
        for (int i = 0; i < 3; i++) sb.push_back({PW'(i * 4), 32'hC000_0000 | 32'(i)});
        seen = 1'b0; dec_ready = 1'b1; rst_n = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (dec_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL halt_unexpected c%0d: got %h want none", cyc, {dec_pc, dec_instr});
                end else begin
                    if ({dec_pc, dec_instr} !== sb[0]) begin
                        n_bad++; $display("FAIL halt_entry c%0d: got %h want %h", cyc, {dec_pc, dec_instr}, sb[0]);
                    end
                    void'(sb.pop_front());
                end
            end
            if (halted) begin
                seen = 1'b1;
                n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_req c%0d: got %b want 0", cyc, imem_req); end
            end
        end
        n_cmp++; if (halted !== 1'b1 || seen !== 1'b1) begin n_bad++; $display("FAIL halt_flag: got %b want 1", halted); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL halt_drain: got %0d left want 0", sb.size()); end
        // Redirect leaves HALT.
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 12'h200;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_redir_req: got %b want 0", imem_req); end
        @(negedge clk); redirect_valid = 1'b0;
        #1;
        n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_exit: got %b want 0", halted); end
        n_cmp++; if ({imem_req, imem_addr} !== {1'b1, 12'h200}) begin
            n_bad++; $display("FAIL halt_restart: got %b/%h want 1/200", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect();
        logic [PW-1:0] exp_pc;
        init_mem();
        do_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        // Queue now holds 0x000..0x008 and 0x00C is in flight.
        redirect_valid = 1'b1; redirect_pc = 12'h100;
        #1;
        n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL redir_pre_valid: got %b want 1", dec_valid); end
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_pre_req: got %b want 0", imem_req); end
        @(negedge clk); redirect_valid = 1'b0; dec_ready = 1'b1;
        #1;
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got %b want 0", dec_valid); end
        exp_pc = 12'h100;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc > 0) begin @(negedge clk); #1; end
            if (imem_req) begin
                n_cmp++;
                if (imem_addr !== exp_pc) begin n_bad++; $display("FAIL redir_addr c%0d: got %h want %h", cyc, imem_addr, exp_pc); end
                sb.push_back({exp_pc, mem[exp_pc[11:2]]});
                exp_pc = exp_pc + 12'd4;
            end
            if (dec_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL redir_stale c%0d: got %h want none", cyc, {dec_pc, dec_instr});
                end else begin
                    if ({dec_pc, dec_instr} !== sb[0]) begin
                        n_bad++; $display("FAIL redir_entry c%0d: got %h want %h", cyc, {dec_pc, dec_instr}, sb[0]);
                    end
                    void'(sb.pop_front());
                end
            end
        end
        n_cmp++; if (exp_pc != 12'h128) begin n_bad++; $display("FAIL redir_reqs: got %h want 128", exp_pc); end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] exp_pc;
        int ndel;
        init_mem();
        sb.delete();
        @(negedge clk);
        w_rst_n = 1'b1; exp_pc = 12'hFF8; ndel = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (w_imem_req) begin
                n_cmp++;
                if (w_imem_addr !== exp_pc) begin n_bad++; $display("FAIL wrap_addr c%0d: got %h want %h", cyc, w_imem_addr, exp_pc); end
                sb.push_back({exp_pc, mem[exp_pc[11:2]]});
                exp_pc = exp_pc + 12'd4;
            end
            if (w_dec_valid) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL wrap_unexpected c%0d: got %h want none", cyc, {w_dec_pc, w_dec_instr});
                end else begin
                    if ({w_dec_pc, w_dec_instr} !== sb[0]) begin
                        n_bad++; $display("FAIL wrap_entry c%0d: got %h want %h", cyc, {w_dec_pc, w_dec_instr}, sb[0]);
                    end
                    void'(sb.pop_front());
                    ndel++;
                end
            end
        end
        n_cmp++; if (ndel < 4) begin n_bad++; $display("FAIL wrap_count: got %0d want >= 4", ndel); end
        n_cmp++; if (w_halted !== 1'b0) begin n_bad++; $display("FAIL wrap_halted: got %b want 0", w_halted); end
    endtask

`ifdef FETCH_STATS_EN
    task automatic test_stats();
        init_mem();
        mem[10] = 32'h0;
        do_reset();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == 6) dec_ready = 1'b1;
        end
        #1;
        n_cmp++; if (stat_fetched !== 32'd10) begin n_bad++; $display("FAIL stat_fetched: got %0d want 10", stat_fetched); end
        n_cmp++; if (stat_stall !== 32'd3) begin n_bad++; $display("FAIL stat_stall: got %0d want 3", stat_stall); end
    endtask
`endif

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
        init_mem();
        test_reset();
        test_basic();
        test_backpressure();
        test_halt();
        test_redirect();
        test_wrap();
`ifdef FETCH_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
